chacha_host_driver: RTL and testbench

Host-side counterpart of the ChaCha20 top-level streaming interface. It owns one job's key, nonce, counter and 512-bit plaintext and pulses `start` to the cipher top. It then answers the cipher's key/nonce/counter chunk requests, streams 16 plaintext words in, collects 16 ciphertext words out, and returns the 512-bit result to the host. It sits between the system/host register file and the cipher top, one job at a time.

---
 rtl/chacha_host_pkg.sv | 22 ++
 rtl/chacha_chunk_responder.sv | 82 ++++++++
 rtl/chacha_host_driver.sv | 197 +++++++++++++++++++
 tb/tb_chacha_host_driver.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_host_pkg.sv
// Shared definitions for the ChaCha20 host-side driver: FSM encoding, chunk
// type codes and word counts.
package chacha_host_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_SERVE,
        S_PLAIN,
        S_COLLECT,
        S_FINISH
    } state_t;

    localparam logic [1:0] CT_KEY     = 2'd0;
    localparam logic [1:0] CT_NONCE   = 2'd1;
    localparam logic [1:0] CT_COUNTER = 2'd2;

    localparam int unsigned KEY_WORDS   = 8;
    localparam int unsigned NONCE_WORDS = 3;
    localparam int unsigned BLOCK_WORDS = 16;

endpackage

// File: rtl/chacha_chunk_responder.sv
// Answers the cipher's key/nonce/counter chunk requests with a registered
// one-cycle response; flags out-of-range requests with an error strobe.
module chacha_chunk_responder
    import chacha_host_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_enable,
    input  logic         i_chunk_request,
    input  logic [1:0]   i_request_type,
    input  logic [4:0]   i_chunk_index,
    input  logic [255:0] i_key,
    input  logic [95:0]  i_nonce,
    input  logic [31:0]  i_counter,
    output logic         o_chunk_valid,
    output logic [1:0]   o_chunk_type,
    output logic [31:0]  o_chunk,
    output logic         o_error
);

    logic        r_valid;
    logic [1:0]  r_type;
    logic [31:0] r_chunk;
    logic        r_error;

    logic        w_take;
    logic [31:0] w_word;
    logic        w_bad;

    // A request still high while its response is on the bus is the same request.
    assign w_take = i_enable && i_chunk_request && !r_valid;

    always_comb begin
        w_word = '0;
        w_bad  = 1'b0;
        case (i_request_type)
            CT_KEY: begin
                if (i_chunk_index < 5'(KEY_WORDS))
                    w_word = i_key[{i_chunk_index[2:0], 5'b0} +: 32];
                else
                    w_bad = 1'b1;
            end
            CT_NONCE: begin
                case (i_chunk_index)
                    5'd0:    w_word = i_nonce[31:0];
                    5'd1:    w_word = i_nonce[63:32];
                    5'd2:    w_word = i_nonce[95:64];
                    default: w_bad  = 1'b1;
                endcase
            end
            CT_COUNTER: begin
                if (i_chunk_index == 5'd0)
                    w_word = i_counter;
                else
                    w_bad = 1'b1;
            end
            default: w_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_type  <= '0;
            r_chunk <= '0;
            r_error <= 1'b0;
        end else begin
            r_valid <= w_take;
            r_error <= w_take && w_bad;
            if (w_take) begin
                r_type  <= i_request_type;
                r_chunk <= w_word;
            end
        end
    end

    assign o_chunk_valid = r_valid;
    assign o_chunk_type  = r_type;
    assign o_chunk       = r_chunk;
    assign o_error       = r_error;

endmodule

// File: rtl/chacha_host_driver.sv
// Host-side driver for one ChaCha20 job: kicks the cipher, serves chunks,
// streams plaintext, collects ciphertext and hands the 512-bit result back.
module chacha_host_driver
    import chacha_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [255:0] key_in,
    input  logic [95:0]  nonce_in,
    input  logic [31:0]  counter_in,
    input  logic [511:0] plaintext_in,
    input  logic         stream_key_in,
    input  logic         stream_nonce_in,
    input  logic         stream_counter_in,
    output logic [511:0] result,
    output logic         result_valid,
    output logic         host_busy,
    output logic         error,
    output logic         start,
    input  logic         busy,
    input  logic         done,
    output logic         use_streamed_key,
    output logic         use_streamed_nonce,
    output logic         use_streamed_counter,
    input  logic         chunk_request,
    input  logic [1:0]   request_type,
    input  logic [4:0]   chunk_index,
    output logic         chunk_valid,
    output logic [1:0]   chunk_type,
    output logic [31:0]  chunk,
    output logic [31:0]  in_state_word,
    output logic         in_state_valid,
    input  logic         in_state_ready,
    input  logic [31:0]  out_state_word,
    input  logic         out_state_valid,
    output logic         out_state_ready
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t r_state, w_state_nxt;

    logic [255:0] r_key;
    logic [95:0]  r_nonce;
    logic [31:0]  r_counter;
    logic [511:0] r_plain;
    logic [3:0]   r_p;
    logic [4:0]   r_q;
    logic [TW-1:0] r_tcnt;

    logic         r_start, r_in_valid, r_out_ready, r_result_valid, r_busy, r_error;
    logic [31:0]  r_in_word;
    logic [511:0] r_result;
    logic         r_use_key, r_use_nonce, r_use_counter;

    logic         w_chunk_valid, w_resp_err;
    logic         w_accept, w_active, w_pt_xfer, w_ct_word, w_ct_store, w_ct_extra;
    logic         w_progress, w_timeout, w_early_done, w_err_set;
    logic [3:0]   w_p_nxt;
    logic [4:0]   w_q_nxt;
    logic         w_start_d, w_in_valid_d, w_out_ready_d, w_result_valid_d, w_busy_d;
    logic [31:0]  w_in_word_d;

    chacha_chunk_responder u_resp (
        .clk             (clk),
        .rst             (rst),
        .i_enable        (r_state == S_SERVE),
        .i_chunk_request (chunk_request),
        .i_request_type  (request_type),
        .i_chunk_index   (chunk_index),
        .i_key           (r_key),
        .i_nonce         (r_nonce),
        .i_counter       (r_counter),
        .o_chunk_valid   (w_chunk_valid),
        .o_chunk_type    (chunk_type),
        .o_chunk         (chunk),
        .o_error         (w_resp_err)
    );

    assign w_accept     = (r_state == S_IDLE) && go;
    assign w_active     = (r_state == S_KICK) || (r_state == S_SERVE) ||
                          (r_state == S_PLAIN) || (r_state == S_COLLECT);
    assign w_pt_xfer    = (r_state == S_PLAIN) && r_in_valid && in_state_ready;
    assign w_ct_word    = (r_state == S_COLLECT) && out_state_valid;
    assign w_ct_store   = w_ct_word && (r_q < 5'(BLOCK_WORDS));
    assign w_ct_extra   = w_ct_word && (r_q == 5'(BLOCK_WORDS));
    assign w_p_nxt      = r_p + {3'b0, w_pt_xfer};
    assign w_q_nxt      = r_q + {4'b0, w_ct_store};
    assign w_progress   = w_chunk_valid || w_pt_xfer || w_ct_word;
    assign w_timeout    = w_active && !w_progress && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
    // done counts as premature unless this cycle's word completes the block.
    assign w_early_done = w_active && done && (w_q_nxt < 5'(BLOCK_WORDS));
    assign w_err_set    = w_resp_err || w_ct_extra || w_early_done || w_timeout;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (go) w_state_nxt = S_KICK;
            S_KICK:    w_state_nxt = S_SERVE;
            S_SERVE:   if (in_state_ready) w_state_nxt = S_PLAIN;
            S_PLAIN:   if (w_pt_xfer && (r_p == 4'(BLOCK_WORDS - 1))) w_state_nxt = S_COLLECT;
            S_COLLECT: if ((w_q_nxt == 5'(BLOCK_WORDS)) && done) w_state_nxt = S_FINISH;
            S_FINISH:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_early_done || w_timeout)
            w_state_nxt = S_FINISH;
    end

    // Outputs are decoded from the next state so that every port is a flop.
    always_comb begin
        w_start_d        = (w_state_nxt == S_KICK);
        w_in_valid_d     = (w_state_nxt == S_PLAIN);
        w_out_ready_d    = (w_state_nxt == S_COLLECT);
        w_result_valid_d = (w_state_nxt == S_FINISH);
        w_busy_d         = (w_state_nxt != S_IDLE);
        w_in_word_d      = '0;
        if (w_state_nxt == S_PLAIN)
            w_in_word_d = r_plain[{w_p_nxt, 5'b0} +: 32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key          <= '0;
            r_nonce        <= '0;
            r_counter      <= '0;
            r_plain        <= '0;
            r_p            <= '0;
            r_q            <= '0;
            r_tcnt         <= '0;
            r_start        <= 1'b0;
            r_in_valid     <= 1'b0;
            r_in_word      <= '0;
            r_out_ready    <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
            r_use_key      <= 1'b0;
            r_use_nonce    <= 1'b0;
            r_use_counter  <= 1'b0;
        end else begin
            r_start        <= w_start_d;
            r_in_valid     <= w_in_valid_d;
            r_in_word      <= w_in_word_d;
            r_out_ready    <= w_out_ready_d;
            r_result_valid <= w_result_valid_d;
            r_busy         <= w_busy_d;
            r_tcnt         <= (!w_active || w_progress) ? '0 : r_tcnt + 1'b1;
            if (w_accept) begin
                r_key         <= key_in;
                r_nonce       <= nonce_in;
                r_counter     <= counter_in;
                r_plain       <= plaintext_in;
                r_use_key     <= stream_key_in;
                r_use_nonce   <= stream_nonce_in;
                r_use_counter <= stream_counter_in;
                r_p           <= '0;
                r_q           <= '0;
                r_result      <= '0;
                r_error       <= 1'b0;
            end else begin
                r_p <= w_p_nxt;
                r_q <= w_q_nxt;
                if (w_ct_store)
                    r_result[{r_q[3:0], 5'b0} +: 32] <= out_state_word;
                if (w_err_set)
                    r_error <= 1'b1;
            end
        end
    end

    assign start                = r_start;
    assign in_state_valid       = r_in_valid;
    assign in_state_word        = r_in_word;
    assign out_state_ready      = r_out_ready;
    assign result               = r_result;
    assign result_valid         = r_result_valid;
    assign host_busy            = r_busy;
    assign error                = r_error;
    assign use_streamed_key     = r_use_key;
    assign use_streamed_nonce   = r_use_nonce;
    assign use_streamed_counter = r_use_counter;
    assign chunk_valid          = w_chunk_valid;

    logic w_unused;
    assign w_unused = busy;

endmodule

// File: tb/tb_chacha_host_driver.sv
// Scoreboard bench for chacha_host_driver: a behavioural cipher drives the
// host driver while a negedge monitor checks every response against queues.
module tb_chacha_host_driver;

    localparam int unsigned TO = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic [255:0] key_in;
    logic [95:0]  nonce_in;
    logic [31:0]  counter_in;
    logic [511:0] plaintext_in;
    logic         stream_key_in, stream_nonce_in, stream_counter_in;
    logic [511:0] result;
    logic         result_valid, host_busy, error, start;
    logic         busy, done;
    logic         use_streamed_key, use_streamed_nonce, use_streamed_counter;
    logic         chunk_request;
    logic [1:0]   request_type;
    logic [4:0]   chunk_index;
    logic         chunk_valid;
    logic [1:0]   chunk_type;
    logic [31:0]  chunk;
    logic [31:0]  in_state_word;
    logic         in_state_valid, in_state_ready;
    logic [31:0]  out_state_word;
    logic         out_state_valid, out_state_ready;

    always #5 clk = ~clk;

    chacha_host_driver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .go(go),
        .key_in(key_in), .nonce_in(nonce_in), .counter_in(counter_in), .plaintext_in(plaintext_in),
        .stream_key_in(stream_key_in), .stream_nonce_in(stream_nonce_in), .stream_counter_in(stream_counter_in),
        .result(result), .result_valid(result_valid), .host_busy(host_busy), .error(error),
        .start(start), .busy(busy), .done(done),
        .use_streamed_key(use_streamed_key), .use_streamed_nonce(use_streamed_nonce),
        .use_streamed_counter(use_streamed_counter),
        .chunk_request(chunk_request), .request_type(request_type), .chunk_index(chunk_index),
        .chunk_valid(chunk_valid), .chunk_type(chunk_type), .chunk(chunk),
        .in_state_word(in_state_word), .in_state_valid(in_state_valid), .in_state_ready(in_state_ready),
        .out_state_word(out_state_word), .out_state_valid(out_state_valid), .out_state_ready(out_state_ready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [1:0]   q_ct[$];
    logic [31:0]  q_cw[$];
    logic [31:0]  q_pw[$];
    logic [512:0] q_res[$];

    logic [1:0]   m_et;
    logic [31:0]  m_ew;
    logic [512:0] m_er;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (chunk_valid) begin
                total++;
                if (q_cw.size() == 0) begin
                    bad++;
                    $display("FAIL chunk_unexpected: got type=%0d chunk=%h required no response", chunk_type, chunk);
                end else begin
                    m_et = q_ct.pop_front();
                    m_ew = q_cw.pop_front();
                    if ({chunk_type, chunk} !== {m_et, m_ew}) begin
                        bad++;
                        $display("FAIL chunk_resp: got type=%0d chunk=%h required type=%0d chunk=%h",
                                 chunk_type, chunk, m_et, m_ew);
                    end
                end
            end
            if (in_state_valid && in_state_ready) begin
                total++;
                if (q_pw.size() == 0) begin
                    bad++;
                    $display("FAIL plain_unexpected: got %h required no transfer", in_state_word);
                end else begin
                    m_ew = q_pw.pop_front();
                    if (in_state_word !== m_ew) begin
                        bad++;
                        $display("FAIL plain_word: got %h required %h", in_state_word, m_ew);
                    end
                end
            end
            if (result_valid) begin
                total++;
                if (q_res.size() == 0) begin
                    bad++;
                    $display("FAIL result_unexpected: got pulse required none");
                end else begin
                    m_er = q_res.pop_front();
                    if ({error, result} !== m_er) begin
                        bad++;
                        $display("FAIL result: got err=%0b %h required err=%0b %h",
                                 error, result, m_er[512], m_er[511:0]);
                    end
                end
            end
        end
    end

    task automatic check_outputs_zero(input string nm);
        logic [13:0] nz;
        nz = {start, chunk_valid, |chunk_type, |chunk, in_state_valid, |in_state_word,
              out_state_ready, |result, result_valid, host_busy, error,
              use_streamed_key, use_streamed_nonce, use_streamed_counter};
        check(nm, 64'(nz), 64'd0);
    endtask

    task automatic req(input logic [1:0] t, input logic [4:0] idx, input logic [31:0] ew, input bit twice);
        q_ct.push_back(t);
        q_cw.push_back(ew);
        chunk_request = 1'b1;
        request_type  = t;
        chunk_index   = idx;
        @(posedge clk); #1;
        if (twice) begin
            @(posedge clk); #1;
        end
        chunk_request = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] ks(input logic [31:0] kb, input logic [31:0] nb,
                                       input logic [31:0] ctr, input int i);
        return (kb + 32'(i % 8)) ^ (nb + 32'(i % 3)) ^ (ctr + 32'(i)) ^ 32'h9E37_79B9;
    endfunction

    task automatic run_job(input logic [31:0] kb, input logic [31:0] nb, input logic [31:0] ctr,
                           input logic [31:0] pb, input logic [2:0] fl, input bit bad_req,
                           input bit rep3, input int rdly, input bit done_same, input bit no_done,
                           input bit rst_mid, input bit stray);
        logic [255:0] k;
        logic [95:0]  n;
        logic [511:0] p, ctx;
        int cnt, c0, dt;
        bit seen;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++)  k[32*i +: 32] = kb + 32'(i);
        for (int i = 0; i < 3; i++)  n[32*i +: 32] = nb + 32'(i);
        for (int i = 0; i < 16; i++) begin
            p[32*i +: 32]   = pb + 32'(i);
            ctx[32*i +: 32] = (pb + 32'(i)) ^ ks(kb, nb, ctr, i);
        end
        key_in = k; nonce_in = n; counter_in = ctr; plaintext_in = p;
        {stream_key_in, stream_nonce_in, stream_counter_in} = fl;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        check("start_on", 64'(start), 64'd1);
        check("busy_on", 64'(host_busy), 64'd1);
        check("error_cleared", 64'(error), 64'd0);
        check("use_streamed", 64'({use_streamed_key, use_streamed_nonce, use_streamed_counter}), 64'(fl));
        @(posedge clk); #1;
        check("start_pulse_end", 64'(start), 64'd0);
        if (stray) begin
            key_in = '1;
            go = 1'b1;
            @(posedge clk); #1;
            go = 1'b0;
        end
        for (int i = 0; i < 8; i++) req(2'd0, 5'(i), kb + 32'(i), rep3 && (i == 3));
        for (int i = 0; i < 3; i++) req(2'd1, 5'(i), nb + 32'(i), 1'b0);
        req(2'd2, 5'd0, ctr, 1'b0);
        if (bad_req) begin
            req(2'd0, 5'd9, 32'd0, 1'b0);
            req(2'd3, 5'd0, 32'd0, 1'b0);
            req(2'd1, 5'd3, 32'd0, 1'b0);
            check("error_bad_req", 64'(error), 64'd1);
        end
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check("no_valid_before_ready", 64'(in_state_valid), 64'd0);
        end
        if (rdly > 0) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 16; i++) q_pw.push_back(pb + 32'(i));
        if (!rst_mid) q_res.push_back({bad_req || no_done, ctx});
        in_state_ready = 1'b1;
        cnt = 0;
        for (int g = 0; g < 60 && cnt < 16; g++) begin
            @(negedge clk);
            if (in_state_valid && in_state_ready) cnt++;
            if (rst_mid && cnt == 7) break;
        end
        if (rst_mid) begin
            @(posedge clk); #1;
            rst = 1'b1;
            in_state_ready = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            check_outputs_zero("rst_mid_outputs");
            q_ct.delete(); q_cw.delete(); q_pw.delete(); q_res.delete();
            return;
        end
        check("plain_count", 64'(cnt), 64'd16);
        @(posedge clk); #1;
        in_state_ready = 1'b0;
        for (int g = 0; g < 20 && !out_state_ready; g++) @(negedge clk);
        check("out_ready", 64'(out_state_ready), 64'd1);
        for (int i = 0; i < 16; i++) begin
            out_state_valid = 1'b1;
            out_state_word  = ctx[32*i +: 32];
            done = done_same && (i == 15);
            @(posedge clk); #1;
        end
        c0 = cyc;
        out_state_valid = 1'b0;
        done = 1'b0;
        if (!no_done && !done_same) begin
            done = 1'b1;
            @(posedge clk); #1;
            done = 1'b0;
        end
        seen = 1'b0;
        dt = -1;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (result_valid && !seen) begin
                seen = 1'b1;
                dt = cyc - c0;
            end
            if (!host_busy) break;
        end
        check("job_end_busy", 64'(host_busy), 64'd0);
        check("result_seen", 64'(seen), 64'd1);
        if (no_done) check("timeout_distance", 64'(dt), 64'(TO));
        check("chunk_q_empty", 64'(q_cw.size()), 64'd0);
        check("plain_q_empty", 64'(q_pw.size()), 64'd0);
        check("result_q_empty", 64'(q_res.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish before 100us");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; go = 1'b0; busy = 1'b0; done = 1'b0;
        key_in = '0; nonce_in = '0; counter_in = '0; plaintext_in = '0;
        stream_key_in = 1'b0; stream_nonce_in = 1'b0; stream_counter_in = 1'b0;
        chunk_request = 1'b0; request_type = '0; chunk_index = '0;
        in_state_ready = 1'b0; out_state_word = '0; out_state_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs_zero("reset_outputs");

        // kb, nb, ctr, pb, flags, bad, rep3, rdly, done_same, no_done, rst_mid, stray
        run_job(32'h1000_0000, 32'h0000_00A0, 32'd1,        32'd0,          3'b111, 0, 0, 0, 0, 0, 0, 1);
        run_job(32'h2000_0000, 32'h0000_00B0, 32'h55,       32'h100,        3'b010, 1, 1, 0, 0, 0, 0, 0);
        run_job(32'h3000_0000, 32'h0000_00C0, 32'd7,        32'hFFFF_FFF0,  3'b101, 0, 0, 5, 1, 0, 0, 0);
        run_job(32'h4000_0000, 32'h0000_00D0, 32'd9,        32'h200,        3'b000, 0, 0, 0, 0, 1, 0, 0);
        run_job(32'h5000_0000, 32'h0000_00E0, 32'd3,        32'h300,        3'b111, 0, 0, 0, 0, 0, 1, 0);
        run_job(32'h6000_0000, 32'h0000_00F0, 32'hDEAD_BEEF, 32'h400,       3'b001, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
